wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Writeback arbiter for the single register-file write port. It collects results from the execution sources: integer (bit/shift/add), multiplier, divider, memory load and branch-link (PC+4). Each cycle it grants at most one source and registers the winner onto the writeback bus. It sits between the execution units and the register file, replacing static per-instruction enable selection when sources complete out of order with variable latency.

## Interface
- NUM_REQ, 5, number of requesters; index 0 has the highest base priority.
- BITWIDTH, 32, result data width.
- REGADDR_W, 5, destination register address width.
- AGE_MAX, 7, wait cycles after which a requester becomes urgent; must be at least 1.

- Clk  in  1  clock, rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- Flush  in  1  synchronous pipeline flush.
- ReqValid  in  NUM_REQ  per-source result valid.
- ReqData  in  NUM_REQ x BITWIDTH  per-source result.
- ReqAddr  in  NUM_REQ x REGADDR_W  per-source destination register.
- ReqReady  out  NUM_REQ  one-hot (or zero) grant; combinational.
- WbEn  out  1  register-file write enable.
- WbAddr  out  REGADDR_W  write address.
- WbData  out  BITWIDTH  write data.
- WbSrc  out  $clog2(NUM_REQ)  index of the source that produced the current write, for debug and scoreboard release.

## Operation
- Handshake: a transfer occurs when ReqValid[i] and ReqReady[i] are both high.
- ReqValid must not depend on ReqReady.
- A source holds ReqValid, ReqData and ReqAddr stable until it is granted.
- Grant selection, when Flush is low:
  - Urgent requesters beat non-urgent ones.
  - Within the same class, the lowest index wins.
  - At most one ReqReady bit is high.
- Urgency: a requester with Age[i] == AGE_MAX is urgent.
- Age[i] counter, width $clog2(AGE_MAX+1):
  - Increments, saturating at AGE_MAX, in each cycle where ReqValid[i] is high and ReqReady[i] is low.
  - Clears to 0 on a grant or whenever ReqValid[i] is low.
- Output stage, a register that always accepts:
  - On a grant, the next cycle shows WbAddr/WbData/WbSrc of the winner.
  - WbEn = 1 unless the winner's address is 0. A write to r0 is consumed (ReqReady high) but WbEn stays 0.
  - With no grant, WbEn = 0 next cycle. WbAddr/WbData/WbSrc hold their previous values.
- Flush high:
  - ReqReady = 0 for all sources.
  - WbEn = 0 next cycle.
  - All Age counters clear.
  - Requesters are not dropped; they remain valid and compete again after Flush deasserts.
- Reset (asynchronous, any time, including while a write is registered): WbEn, WbAddr, WbData, WbSrc and all Age counters go to 0 immediately. ReqReady is combinational and therefore reflects the cleared ages.

## Timing
- Latency: grant in cycle N -> WbEn/WbAddr/WbData valid in cycle N+1 for exactly one cycle.
- Throughput: one writeback per cycle. Back-to-back grants to the same or to different sources are allowed.
- ReqReady is a combinational function of ReqValid, Flush and the registered Age counters, with no path from outputs.
- Simultaneous urgent requesters: the lowest index wins. The others keep saturated age and win in subsequent cycles in index order.
- Starvation bound with aging enabled: a valid requester is granted within AGE_MAX + NUM_REQ cycles.
- Reset release: the first grant is possible in the first clock edge with Rst_n high; WbEn can first be 1 on the following cycle.

## Configuration
- WB_ARB_AGING_EN defined: Age counters and the urgency class exist as described.
- WB_ARB_AGING_EN undefined:
  - Pure fixed priority, lowest index wins.
  - No Age registers are instantiated.
  - Flush affects only ReqReady and WbEn.
  - The AGE_MAX parameter is ignored.

## Structure
- Package wb_arb_pkg:
  - Default localparams NUM_REQ_DEF, BITWIDTH_DEF, REGADDR_W_DEF.
  - Source-index enum: SRC_MEM=0, SRC_DIV=1, SRC_MULT=2, SRC_INT=3, SRC_BJ=4. Slow, variable-latency sources get the higher base priority.
  - Typedef wb_req_t, a packed struct of data and addr.
- Sub-module wb_prio_pick: a parameterised lowest-index-first one-hot picker. It is instantiated twice, once on the urgent mask and once on the full valid mask; the urgent result is selected when it is non-zero.

## Test plan
- Single request: ReqValid=5'b01000, ReqAddr[3]=5'd7, ReqData[3]=32'h1234 -> ReqReady=5'b01000 same cycle; next cycle WbEn=1, WbAddr=7, WbData=32'h1234, WbSrc=3.
- Priority: ReqValid=5'b10110 -> grants in order index 1, then 2, then 4 over three consecutive cycles as each deasserts after its grant; WbEn high for 3 cycles.
- Aging (WB_ARB_AGING_EN): index 0 is kept continuously valid with new data and index 4 is held valid -> index 4 is granted on the cycle after it has waited 7 cycles (Age=7), then index 0 resumes.
- r0 write: ReqValid[2]=1 with ReqAddr[2]=0 -> ReqReady[2]=1; next cycle WbEn=0, WbSrc=2.
- Flush: ReqValid=5'b00011 with Flush=1 for 2 cycles -> ReqReady=0 and WbEn=0 in those cycles; the cycle after Flush deasserts, ReqReady=5'b00001.
- Reset mid-operation: assert Rst_n=0 asynchronously in a cycle where WbEn=1 -> WbEn, WbAddr, WbData, WbSrc and Age counters read 0 before the next clock edge.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared defaults, source indices and the writeback request type for wb_arbiter
package wb_arb_pkg;
  localparam int NUM_REQ_DEF   = 5;
  localparam int BITWIDTH_DEF  = 32;
  localparam int REGADDR_W_DEF = 5;
  typedef enum logic [2:0] {
    SRC_MEM  = 3'd0,
    SRC_DIV  = 3'd1,
    SRC_MULT = 3'd2,
    SRC_INT  = 3'd3,
    SRC_BJ   = 3'd4
  } src_e;
  typedef struct packed {
    logic [BITWIDTH_DEF-1:0]  data;
    logic [REGADDR_W_DEF-1:0] addr;
  } wb_req_t;
endpackage

// File: rtl/wb_prio_pick.sv
// wb_prio_pick: lowest-index-first one-hot picker
// Ports: req (request mask), gnt (one-hot lowest set bit of req, or zero)
module wb_prio_pick #(
  parameter int N = 5
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);
  // two's complement isolates the lowest set bit
  assign gnt = req & (~req + N'(1));
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: registered single-port writeback arbiter with optional aging
// Ports: Clk, Rst_n (async active-low), Flush; ReqValid/ReqData/ReqAddr per source,
// ReqReady one-hot combinational grant; WbEn/WbAddr/WbData/WbSrc registered writeback.
// Optional feature: define WB_ARB_AGING_EN to add per-source age counters and an urgent class.
module wb_arbiter
  import wb_arb_pkg::*;
#(
  parameter  int NUM_REQ   = NUM_REQ_DEF,
  parameter  int BITWIDTH  = BITWIDTH_DEF,
  parameter  int REGADDR_W = REGADDR_W_DEF,
  parameter  int AGE_MAX   = 7,
  localparam int SRC_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                                Clk,
  input  logic                                Rst_n,
  input  logic                                Flush,
  input  logic [NUM_REQ-1:0]                  ReqValid,
  input  logic [NUM_REQ-1:0][BITWIDTH-1:0]    ReqData,
  input  logic [NUM_REQ-1:0][REGADDR_W-1:0]   ReqAddr,
  output logic [NUM_REQ-1:0]                  ReqReady,
  output logic                                WbEn,
  output logic [REGADDR_W-1:0]                WbAddr,
  output logic [BITWIDTH-1:0]                 WbData,
  output logic [SRC_W-1:0]                    WbSrc
);
  if (AGE_MAX < 1) begin : g_bad_age
    $error("wb_arbiter: AGE_MAX must be at least 1");
  end
  logic [NUM_REQ-1:0]   pick_all;
  logic [BITWIDTH-1:0]  win_data;
  logic [REGADDR_W-1:0] win_addr;
  logic [SRC_W-1:0]     win_idx;
  wb_prio_pick #(.N(NUM_REQ)) u_pick_all (.req(ReqValid), .gnt(pick_all));
`ifdef WB_ARB_AGING_EN
  localparam int AGE_W = $clog2(AGE_MAX + 1);
  logic [NUM_REQ-1:0][AGE_W-1:0] age;
  logic [NUM_REQ-1:0]            urgent;
  logic [NUM_REQ-1:0]            pick_urg;
  always_comb begin
    urgent = '0;
    for (int i = 0; i < NUM_REQ; i++)
      urgent[i] = ReqValid[i] && (age[i] == AGE_W'(AGE_MAX));
  end
  wb_prio_pick #(.N(NUM_REQ)) u_pick_urg (.req(urgent), .gnt(pick_urg));
  assign ReqReady = Flush ? '0 : (|pick_urg ? pick_urg : pick_all);
  // age counts cycles spent waiting; any grant, idle cycle or flush restarts it
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) age <= '0;
    else
      for (int i = 0; i < NUM_REQ; i++)
        age[i] <= (Flush || !ReqValid[i] || ReqReady[i]) ? '0 :
                  (age[i] == AGE_W'(AGE_MAX)) ? age[i] : age[i] + AGE_W'(1);
  end
`else
  assign ReqReady = Flush ? '0 : pick_all;
`endif
  always_comb begin
    win_data = '0;
    win_addr = '0;
    win_idx  = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (ReqReady[i]) begin
        win_data = ReqData[i];
        win_addr = ReqAddr[i];
        win_idx  = SRC_W'(i);
      end
  end
  // r0 writes are consumed but never enable the register file
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      WbEn   <= 1'b0;
      WbAddr <= '0;
      WbData <= '0;
      WbSrc  <= '0;
    end else begin
      WbEn <= |ReqReady && (win_addr != '0);
      if (|ReqReady) begin
        WbAddr <= win_addr;
        WbData <= win_data;
        WbSrc  <= win_idx;
      end
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: scoreboard bench for wb_arbiter with directed per-cycle expectations
module tb_wb_arbiter;
  import wb_arb_pkg::*;
  localparam int N = NUM_REQ_DEF;
  localparam int W = BITWIDTH_DEF;
  localparam int A = REGADDR_W_DEF;
  logic                Clk = 1'b0;
  logic                Rst_n = 1'b0;
  logic                Flush = 1'b0;
  logic [N-1:0]        ReqValid = '0;
  logic [N-1:0][W-1:0] ReqData = '0;
  logic [N-1:0][A-1:0] ReqAddr = '0;
  logic [N-1:0]        ReqReady;
  logic                WbEn;
  logic [A-1:0]        WbAddr;
  logic [W-1:0]        WbData;
  logic [2:0]          WbSrc;
  typedef struct {
    logic [N-1:0] rdy;
    logic         en;
    wb_req_t      wb;
    logic [2:0]   src;
  } exp_t;
  exp_t q[$];
  int vectors = 0;
  int errors = 0;
  always #5 Clk = ~Clk;
  wb_arbiter dut (
    .Clk(Clk), .Rst_n(Rst_n), .Flush(Flush),
    .ReqValid(ReqValid), .ReqData(ReqData), .ReqAddr(ReqAddr),
    .ReqReady(ReqReady), .WbEn(WbEn), .WbAddr(WbAddr), .WbData(WbData), .WbSrc(WbSrc)
  );
  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
    end
  endtask
  always @(negedge Clk) begin
    if (q.size() > 0) begin : pop
      exp_t e;
      e = q.pop_front();
      cmp("ReqReady", 64'(ReqReady), 64'(e.rdy));
      cmp("WbEn", 64'(WbEn), 64'(e.en));
      cmp("WbAddr", 64'(WbAddr), 64'(e.wb.addr));
      cmp("WbData", 64'(WbData), 64'(e.wb.data));
      cmp("WbSrc", 64'(WbSrc), 64'(e.src));
    end
  end
  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask
  task automatic chk(input logic [N-1:0] rdy, input logic en, input logic [A-1:0] addr,
                     input logic [W-1:0] data, input src_e src);
    exp_t e;
    e.rdy = rdy;
    e.en = en;
    e.wb.addr = addr;
    e.wb.data = data;
    e.src = src;
    q.push_back(e);
  endtask
  initial begin
    #3;
    cmp("reset WbEn", 64'(WbEn), 64'd0);
    cmp("reset WbAddr", 64'(WbAddr), 64'd0);
    cmp("reset WbData", 64'(WbData), 64'd0);
    cmp("reset WbSrc", 64'(WbSrc), 64'd0);
    #4 Rst_n = 1'b1;
    cyc(); chk(5'b00000, 0, 0, 0, SRC_MEM);
    cyc(); ReqAddr[3] = 5'd7; ReqData[3] = 32'h1234; ReqValid = 5'b01000;
    chk(5'b01000, 0, 0, 0, SRC_MEM);
    cyc(); ReqValid = 5'b00000; chk(5'b00000, 1, 7, 32'h1234, SRC_INT);
    cyc();
    ReqAddr[1] = 5'd1; ReqData[1] = 32'hAAAA_0001;
    ReqAddr[2] = 5'd2; ReqData[2] = 32'hBBBB_0002;
    ReqAddr[4] = 5'd4; ReqData[4] = 32'hCCCC_0004;
    ReqValid = 5'b10110; chk(5'b00010, 0, 7, 32'h1234, SRC_INT);
    cyc(); ReqValid = 5'b10100; chk(5'b00100, 1, 1, 32'hAAAA_0001, SRC_DIV);
    cyc(); ReqValid = 5'b10000; chk(5'b10000, 1, 2, 32'hBBBB_0002, SRC_MULT);
    cyc(); ReqValid = 5'b00000; chk(5'b00000, 1, 4, 32'hCCCC_0004, SRC_BJ);
    cyc(); ReqAddr[2] = 5'd0; ReqData[2] = 32'hDEAD_0002; ReqValid = 5'b00100;
    chk(5'b00100, 0, 4, 32'hCCCC_0004, SRC_BJ);
    cyc(); ReqValid = 5'b00000; chk(5'b00000, 0, 0, 32'hDEAD_0002, SRC_MULT);
    cyc(); ReqAddr[0] = 5'd3; ReqData[0] = 32'h5550; ReqValid = 5'b00011; Flush = 1'b1;
    chk(5'b00000, 0, 0, 32'hDEAD_0002, SRC_MULT);
    cyc(); chk(5'b00000, 0, 0, 32'hDEAD_0002, SRC_MULT);
    cyc(); Flush = 1'b0; chk(5'b00001, 0, 0, 32'hDEAD_0002, SRC_MULT);
    cyc(); ReqValid = 5'b00010; chk(5'b00010, 1, 3, 32'h5550, SRC_MEM);
    cyc(); ReqData[0] = 32'h6660; ReqValid = 5'b00001; chk(5'b00001, 1, 1, 32'hAAAA_0001, SRC_DIV);
    cyc(); ReqData[0] = 32'h7770; chk(5'b00001, 1, 3, 32'h6660, SRC_MEM);
    cyc(); ReqValid = 5'b00000; chk(5'b00000, 1, 3, 32'h7770, SRC_MEM);
`ifdef WB_ARB_AGING_EN
    for (int k = 0; k < 7; k++) begin
      cyc(); ReqData[0] = 32'h0A00 + 32'(k); ReqValid = 5'b10001;
      if (k == 0) chk(5'b00001, 0, 3, 32'h7770, SRC_MEM);
      else chk(5'b00001, 1, 3, 32'h0A00 + 32'(k - 1), SRC_MEM);
    end
    cyc(); ReqData[0] = 32'h0A07; chk(5'b10000, 1, 3, 32'h0A06, SRC_MEM);
    cyc(); ReqValid = 5'b00001; chk(5'b00001, 1, 4, 32'hCCCC_0004, SRC_BJ);
    cyc(); ReqValid = 5'b00000; chk(5'b00000, 1, 3, 32'h0A07, SRC_MEM);
`endif
    cyc(); ReqAddr[3] = 5'd7; ReqData[3] = 32'h1234; ReqValid = 5'b01000;
    cyc(); ReqValid = 5'b00000; chk(5'b00000, 1, 7, 32'h1234, SRC_INT);
    @(negedge Clk);
    #2 Rst_n = 1'b0;
    #1;
    cmp("async WbEn", 64'(WbEn), 64'd0);
    cmp("async WbAddr", 64'(WbAddr), 64'd0);
    cmp("async WbData", 64'(WbData), 64'd0);
    cmp("async WbSrc", 64'(WbSrc), 64'd0);
    cyc(); Rst_n = 1'b1; chk(5'b00000, 0, 0, 0, SRC_MEM);
    cyc(); ReqData[0] = 32'h8880; ReqValid = 5'b00001; chk(5'b00001, 0, 0, 0, SRC_MEM);
    cyc(); ReqValid = 5'b00000; chk(5'b00000, 1, 3, 32'h8880, SRC_MEM);
    repeat (2) @(negedge Clk);
    #1;
    cmp("scoreboard drained", 64'(q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
